sample_batcher: RTL
===================

SAMPLE_BATCHER -- requirements
Module: sample_batcher

Interface
REQ-001 SHALL have parameter M, default 4: control-bit vector width per input sample.
REQ-002 SHALL have parameter DSR, default 12: samples per batch, the downsampling ratio.
REQ-003 SHALL have parameter LA, default 4: batches per lookahead phase.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_bits, input, M bits: one control-bit sample.
REQ-007 SHALL have port in_valid, input, 1 bit: in_bits is accepted this cycle.
REQ-008 SHALL have port batch_out, output, M*DSR bits: newest complete batch, for the lookback input.
REQ-009 SHALL have port batch_valid, output, 1 bit: one-cycle pulse marking new batch_out, la_sample and cb_sample.
REQ-010 SHALL have port la_sample, output, M*DSR bits: batch feeding the lookahead recursion.
REQ-011 SHALL have port cb_sample, output, M*DSR bits: batch feeding the backward-compute recursion.
REQ-012 SHALL have port la_valid, output, 1 bit: la_sample holds real data.
REQ-013 SHALL have port cb_valid, output, 1 bit: cb_sample holds real data.
REQ-014 SHALL have port propagate, output, 1 bit: load the lookahead state into the compute recursion.

Function
REQ-015 SHALL place sample k of a batch (k=0 oldest) at bits [M*k +: M].
REQ-016 SHALL count accepted samples 0..DSR-1, hold the count while in_valid=0, and wrap the count to 0 on the DSR-th sample.
REQ-017 SHALL pulse batch_valid exactly one cycle after the DSR-th accepted sample, with batch_out equal to that batch.
REQ-018 SHALL accept an in_valid sample in a batch_valid cycle as sample 0 of the next batch, with no gaps.
REQ-019 SHALL store each batch in a 3*LA-slot ring; the write pointer wraps from 3*LA-1 to 0.
REQ-020 SHALL track phase index p (0..LA-1) for each batch within the filling phase; p wraps to 0 after LA-1.
REQ-021 SHALL drive la_sample, on the batch_valid pulse for phase-position p, with batch LA-1-p of the most recent completed phase (reverse order).
REQ-022 SHALL drive cb_sample, on the same pulse, with batch LA-1-p of the phase before that.
REQ-023 SHALL assert propagate only together with batch_valid and only when p=0.
REQ-024 SHALL assert la_valid and hold it once at least 1 phase has completed since reset.
REQ-025 SHALL assert cb_valid and hold it once at least 2 phases have completed since reset.
REQ-026 SHALL hold outputs between pulses; the batch_out, la_sample and cb_sample buses keep their last value.

Reset
REQ-027 SHALL, with rst=0 at a clock edge, clear the sample count, p, write pointer and phase-completion count.
REQ-028 SHALL, with rst=0 at a clock edge, set all outputs to 0.
REQ-029 SHALL discard a partial batch when reset is applied mid-batch.
REQ-030 SHALL ignore in_valid while rst=0; ring contents need not be cleared.
REQ-031 SHALL accept in_valid as sample 0 on the first edge with rst=1.

Configuration
REQ-032 SHALL, with SAMPLE_BATCHER_STATS_EN defined, add output batch_count (16 bits), incremented on each batch_valid, saturating at 16'hFFFF, and cleared by reset.
REQ-033 SHALL, without SAMPLE_BATCHER_STATS_EN, omit the batch_count port and its logic entirely.

Structure
REQ-034 SHALL place the batch-word typedef (logic [M*DSR-1:0]) and the ring-depth constant function (3*LA) in the shared package.
REQ-035 SHALL implement the ring as sub-module sample_batch_ram: one write port, two registered read ports, no reset on storage.

Verification
REQ-036 SHALL verify with M=4, DSR=12, LA=2, in_valid=1 continuously, in_bits=sample index mod 16: batch_valid on cycles 12, 24, 36…, and the first batch_out = 0xBA9876543210.
REQ-037 SHALL verify in_valid toggling 1,0,1,0…: the first batch_valid comes one cycle after the 12th accepted sample, with no duplicated or skipped samples.
REQ-038 SHALL verify that batches B0..B5 (continuous input) give la_valid from B2's pulse, cb_valid from B4's pulse, la_sample B3,B2 at B4,B5, cb_sample B1,B0 at B4,B5, and propagate at B0, B2 and B4.
REQ-039 SHALL verify rst=0 after sample 7 of a batch: outputs go to 0, and the next batch_valid comes 12 samples after release.
REQ-040 SHALL verify 20 phases run continuously: the ring wraps with no corruption, and la_sample/cb_sample match a reference model every pulse.
REQ-041 SHALL verify, with SAMPLE_BATCHER_STATS_EN, that batch_count is preloaded by forcing to 16'hFFFE and then saturates at 16'hFFFF after two further batches.

Source files
------------

// File: rtl/sample_batcher_pkg.sv
// Shared types and helpers for the sample batcher.
//   batch_t     : one packed batch word for the default M/DSR configuration
//   ring_depth  : number of batch slots in the ring for a given lookahead length
//   cw          : counter/address width for a range of n values (minimum 1 bit)
package sample_batcher_pkg;

   localparam int SB_M   = 4;
   localparam int SB_DSR = 12;
   localparam int SB_LA  = 4;

   typedef logic [SB_M*SB_DSR-1:0] batch_t;

   // Three phases are live at once: the one filling, the lookahead source
   // and the backward-compute source.
   function automatic int ring_depth(input int la);
      return 3 * la;
   endfunction

   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sample_batch_ram.sv
// Batch ring storage: one write port, two registered read ports.
//   clk                    : clock
//   rst                    : synchronous active-low reset (read registers only)
//   i_we/i_waddr/i_wdata   : write port
//   i_re_a/i_raddr_a       : read port A enable/address -> o_rdata_a (next cycle)
//   i_re_b/i_raddr_b       : read port B enable/address -> o_rdata_b (next cycle)
// Read registers hold their value while their enable is low.
module sample_batch_ram #(
   parameter int W     = 48,
   parameter int DEPTH = 12,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re_a,
   input  logic [AW-1:0] i_raddr_a,
   input  logic          i_re_b,
   input  logic [AW-1:0] i_raddr_b,
   output logic [W-1:0]  o_rdata_a,
   output logic [W-1:0]  o_rdata_b
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         o_rdata_a <= '0;
         o_rdata_b <= '0;
      end else begin
         if (i_re_a) o_rdata_a <= r_mem[i_raddr_a];
         if (i_re_b) o_rdata_b <= r_mem[i_raddr_b];
      end
   end

endmodule

// File: rtl/sample_batcher.sv
// Groups M-bit control samples into DSR-sample batches and replays earlier
// phases (LA batches each) in reverse order for lookahead / backward compute.
//   clk, rst                 : clock, synchronous active-low reset
//   in_bits, in_valid        : sample input
//   batch_out, batch_valid   : newest batch and its one-cycle pulse
//   la_sample, la_valid      : batch LA-1-p of the last completed phase
//   cb_sample, cb_valid      : batch LA-1-p of the phase before that
//   propagate                : pulse on the first batch of each phase
//   batch_count              : saturating batch counter (SAMPLE_BATCHER_STATS_EN only)
module sample_batcher
   import sample_batcher_pkg::*;
#(
   parameter int M   = SB_M,
   parameter int DSR = SB_DSR,
   parameter int LA  = SB_LA
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [M-1:0]     in_bits,
   input  logic             in_valid,
   output logic [M*DSR-1:0] batch_out,
   output logic             batch_valid,
   output logic [M*DSR-1:0] la_sample,
   output logic [M*DSR-1:0] cb_sample,
   output logic             la_valid,
   output logic             cb_valid,
   output logic             propagate
`ifdef SAMPLE_BATCHER_STATS_EN
   ,output logic [15:0]     batch_count
`endif
);

   localparam int DEPTH = ring_depth(LA);
   localparam int CW    = cw(DSR);
   localparam int PW    = cw(LA);
   localparam int AW    = cw(DEPTH);

   logic [CW-1:0]          r_cnt;
   logic [PW-1:0]          r_p;
   logic [AW-1:0]          r_wp;
   logic [1:0]             r_phases;
   logic [M*(DSR-1)-1:0]   r_acc;

   logic                   w_done;
   logic [M*DSR-1:0]       w_batch;
   logic [AW:0]            w_la_back;
   logic [AW:0]            w_cb_back;
   logic [AW-1:0]          w_la_addr;
   logic [AW-1:0]          w_cb_addr;

   assign w_done  = in_valid && (r_cnt == CW'(DSR-1));
   assign w_batch = {in_bits, r_acc};

   // Batch n lands in slot n mod DEPTH. The lookahead source is batch
   // n-2p-1 and the compute source is LA further back; both distances are
   // below DEPTH, so one conditional wrap is enough.
   always_comb begin
      w_la_back = (AW+1)'(2*int'(r_p) + 1);
      w_cb_back = (AW+1)'(2*int'(r_p) + 1 + LA);
      w_la_addr = ({1'b0, r_wp} >= w_la_back)
                ? AW'({1'b0, r_wp} - w_la_back)
                : AW'({1'b0, r_wp} + (AW+1)'(DEPTH) - w_la_back);
      w_cb_addr = ({1'b0, r_wp} >= w_cb_back)
                ? AW'({1'b0, r_wp} - w_cb_back)
                : AW'({1'b0, r_wp} + (AW+1)'(DEPTH) - w_cb_back);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_p         <= '0;
         r_wp        <= '0;
         r_phases    <= '0;
         r_acc       <= '0;
         batch_out   <= '0;
         batch_valid <= 1'b0;
         la_valid    <= 1'b0;
         cb_valid    <= 1'b0;
         propagate   <= 1'b0;
      end else begin
         batch_valid <= 1'b0;
         propagate   <= 1'b0;
         if (w_done) begin
            r_cnt       <= '0;
            batch_out   <= w_batch;
            batch_valid <= 1'b1;
            propagate   <= (r_p == '0);
            r_wp        <= (r_wp == AW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
            if (r_p == PW'(LA-1)) begin
               r_p <= '0;
               if (r_phases != 2'd2) r_phases <= r_phases + 2'd1;
            end else begin
               r_p <= r_p + 1'b1;
            end
            // Validity tracks phases completed before this batch.
            if (r_phases != 2'd0) la_valid <= 1'b1;
            if (r_phases == 2'd2) cb_valid <= 1'b1;
         end else if (in_valid) begin
            r_cnt <= r_cnt + 1'b1;
            for (int k = 0; k < DSR-1; k++) begin
               if (r_cnt == CW'(k)) r_acc[M*k +: M] <= in_bits;
            end
         end
      end
   end

`ifdef SAMPLE_BATCHER_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst)
         batch_count <= '0;
      else if (w_done && batch_count != 16'hFFFF)
         batch_count <= batch_count + 16'd1;
   end
`endif

   // Reads are only issued once the source phase exists, so the sample
   // buses stay at zero until their valid flag rises.
   sample_batch_ram #(
      .W     (M*DSR),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_done),
      .i_waddr   (r_wp),
      .i_wdata   (w_batch),
      .i_re_a    (w_done && (r_phases != 2'd0)),
      .i_raddr_a (w_la_addr),
      .i_re_b    (w_done && (r_phases == 2'd2)),
      .i_raddr_b (w_cb_addr),
      .o_rdata_a (la_sample),
      .o_rdata_b (cb_sample)
   );

endmodule
